fifo_read_ctrl: RTL
===================

Name: fifo_read_ctrl

Overview:
- Read-side controller for the FIFO memory block, in a single clock domain.
- Compares its own Gray read pointer with an already-synchronised Gray write pointer to derive empty and occupancy.
- Issues reads to the memory (r_addr / ena), absorbs the one-cycle memory read latency, and presents words on a valid/ready output port.
- Exports its Gray read pointer so the write side can synchronise it for full detection.

Parameters:
- WORD, 8, data word width in bits.
- LEN_POW, 3, log2 of memory depth (depth LEN = 2^LEN_POW = 8).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- wptr_gray_sync  in  LEN_POW+1  write pointer, Gray coded, already synchronised into clk domain.
- rptr_gray  out  LEN_POW+1  registered read pointer, Gray coded.
- ena  out  1  memory read enable (combinational issue strobe).
- r_addr  out  LEN_POW  memory read address = rbin[LEN_POW-1:0].
- r_word  in  WORD  memory read data; valid the cycle after an edge sampling ena=1.
- dout  out  WORD  output word.
- dout_valid  out  1  dout holds a valid word.
- dout_ready  in  1  consumer accepts dout this cycle.
- empty  out  1  memory holds no unread words.
- level  out  LEN_POW+1  words in memory not yet issued.

Behaviour:
- Pointers:
  - Internal binary read pointer rbin is LEN_POW+1 bits, including the wrap bit.
  - rptr_gray = rbin ^ (rbin >> 1), registered and updated on the same edge as rbin.
  - Arithmetic is modulo 2^(LEN_POW+1).
- Empty and level:
  - empty = (rptr_gray == wptr_gray_sync), combinational.
  - wbin = Gray-to-binary of wptr_gray_sync.
  - level = wbin - rbin (mod 2^(LEN_POW+1)), combinational, range 0..LEN.
- Output buffer:
  - Two entries: head register (drives dout) plus one skid entry.
  - in_flight flag marks a read issued last cycle whose data arrives this cycle.
  - occ = buffered entries (0..2).
- Issue:
  - issue = !empty && (occ + in_flight - pop) < 2, where pop = dout_valid && dout_ready.
  - ena = issue; r_addr = rbin[LEN_POW-1:0].
  - On an edge with issue=1: rbin <= rbin+1 and in_flight <= 1; otherwise in_flight <= 0.
- Capture:
  - On an edge with in_flight=1, r_word is written to the head if the head is free after pop, else to skid.
  - On pop, skid (if valid) moves to the head.
  - Pop and capture on the same edge are both honoured; ordering is strictly FIFO.
- Latency:
  - First word becomes visible 2 cycles after issue: cycle 0 issue, cycle 1 r_word, cycle 2 dout_valid.
  - Sustained throughput is 1 word/cycle with dout_ready held high.
- Backpressure:
  - dout and dout_valid are held stable while dout_valid=1 and dout_ready=0.
  - No more than 2 words are ever held or in flight; no word is dropped or duplicated.
- Wrap-around:
  - r_addr wraps 7->0.
  - The rbin MSB toggles every LEN reads; empty stays correct across the wrap.
- wptr_gray_sync may advance in any cycle; issue uses its current value only.
- Reset:
  - rbin=0, rptr_gray=0, in_flight=0, buffer cleared.
  - dout_valid=0, dout=0, ena=0 (forced during rst).
  - Reset mid-operation discards buffered and in-flight words.

Test Plan:
- Reset: assert rst 2 cycles with wptr_gray_sync=0 -> rptr_gray=0, empty=1, level=0, dout_valid=0, ena=0.
- Single word: memory addr0=0x11, wptr_gray_sync 0->1 -> ena=1 with r_addr=0 that cycle; dout_valid=1 with dout=0x11 two cycles later; rptr_gray=1, empty=1.
- Burst: memory holds 1..8, wptr_gray_sync=0b1100 (wbin 8), dout_ready=1 -> level=8 initially; dout 1,2,...,8 on 8 consecutive cycles; final rptr_gray=0b1100, empty=1.
- Backpressure: same fill, dout_ready=0 -> exactly 2 issues, then ena=0, dout=1 held, level=6. Release dout_ready -> remaining words stream in order 1..8.
- Wrap-around: push 12 words in two phases (8, then 4 after draining) -> r_addr sequence 0..7,0..3; rbin ends at 12; rptr_gray ends at 0b1010; data in order.
- Reset mid-burst: assert rst after 3 pops in the burst -> dout_valid=0 next cycle, rptr_gray=0, no further pops of pre-reset data.

Source files
------------

// File: rtl/fifo_read_ctrl.sv
// Read side of the FIFO: Gray pointer compare for empty/level, memory read issue,
// and a two-entry output buffer (head + skid) that absorbs the one-cycle read latency.
module fifo_read_ctrl #(
  parameter int WORD    = 8,
  parameter int LEN_POW = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LEN_POW:0]   wptr_gray_sync,
  output logic [LEN_POW:0]   rptr_gray,
  output logic               ena,
  output logic [LEN_POW-1:0] r_addr,
  input  logic [WORD-1:0]    r_word,
  output logic [WORD-1:0]    dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               empty,
  output logic [LEN_POW:0]   level
);

  logic [LEN_POW:0] rbin_q, rbin_d;
  logic [LEN_POW:0] rgray_q, rgray_d;
  logic [LEN_POW:0] wbin;
  logic             inFlight_q, inFlight_d;
  logic             headValid_q, headValid_d;
  logic             skidValid_q, skidValid_d;
  logic [WORD-1:0]  head_q, head_d;
  logic [WORD-1:0]  skid_q, skid_d;
  logic             pop;
  logic             issue;
  logic [2:0]       demand;

  always_comb begin
    wbin = '0;
    for (int i = 0; i <= LEN_POW; i++) begin
      wbin[i] = ^(wptr_gray_sync >> i);
    end
  end

  assign empty      = (rgray_q == wptr_gray_sync);
  assign level      = wbin - rbin_q;
  assign pop        = headValid_q && dout_ready;
  // Words that would still be held or in flight after this edge, excluding a new issue.
  assign demand     = {2'b00, headValid_q} + {2'b00, skidValid_q} + {2'b00, inFlight_q}
                      - {2'b00, pop};
  assign issue      = !empty && (demand < 3'd2);
  assign ena        = issue && !rst;
  assign r_addr     = rbin_q[LEN_POW-1:0];
  assign rptr_gray  = rgray_q;
  assign dout       = head_q;
  assign dout_valid = headValid_q;

  always_comb begin
    rbin_d      = rbin_q;
    inFlight_d  = issue;
    headValid_d = headValid_q;
    head_d      = head_q;
    skidValid_d = skidValid_q;
    skid_d      = skid_q;
    if (issue) begin
      rbin_d = rbin_q + {{LEN_POW{1'b0}}, 1'b1};
    end
    if (pop) begin
      headValid_d = skidValid_q;
      head_d      = skidValid_q ? skid_q : head_q;
      skidValid_d = 1'b0;
    end
    // Arriving word goes behind whatever remains buffered after the pop.
    if (inFlight_q) begin
      if (!headValid_d) begin
        headValid_d = 1'b1;
        head_d      = r_word;
      end else begin
        skidValid_d = 1'b1;
        skid_d      = r_word;
      end
    end
    rgray_d = rbin_d ^ (rbin_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rbin_q      <= '0;
      rgray_q     <= '0;
      inFlight_q  <= 1'b0;
      headValid_q <= 1'b0;
      skidValid_q <= 1'b0;
      head_q      <= '0;
      skid_q      <= '0;
    end else begin
      rbin_q      <= rbin_d;
      rgray_q     <= rgray_d;
      inFlight_q  <= inFlight_d;
      headValid_q <= headValid_d;
      skidValid_q <= skidValid_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
    end
  end

endmodule
